regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//  Multi-cycle control FSM sequencing the 4x8 register file and ALU of the CPU.
//  Accepts 8-bit instructions over a valid/ready handshake, drives regfile read selects,
//  write enable/select and ALU op, and muxes write data between ALU result and an immediate.
//  Sits between the instruction source (memory/loader) and the register-file/ALU datapath.
// PARAMETERS
//  DATA_W   8  datapath width (regfile, immediate, ALU result)
//  SEL_W    2  register select width (4 registers)
//  CNT_W    8  retired-instruction counter width
// PORTS
//  clk          in   1       single clock, all state updates on rising edge
//  reset        in   1       synchronous, active-high
//  instr_valid  in   1       instruction/immediate byte on instr_data is valid
//  instr_data   in   DATA_W  instr: [7:4] opcode, [3:2] rd, [1:0] rs; or LDI immediate byte
//  instr_ready  out  1       sequencer accepts a byte this cycle
//  resume       in   1       leaves HALT when asserted (one-cycle pulse sufficient)
//  alu_result   in   DATA_W  combinational ALU output from port_a/port_b data
//  write_en     out  1       regfile write strobe
//  write_sel    out  SEL_W   regfile destination
//  port_a_sel   out  SEL_W   regfile read A select (= rd)
//  port_b_sel   out  SEL_W   regfile read B select (= rs)
//  alu_op       out  3       0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 PASS_B
//  wr_data      out  DATA_W  regfile input_data (alu_result or latched immediate)
//  halted       out  1       high while in HALT
//  illegal_op   out  1       one-cycle pulse in DECODE on undefined opcode
//  retired      out  CNT_W   count of completed instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE; IR, IMM, retired, alu_op, selects = 0; write_en, illegal_op, halted = 0;
//   instr_ready=1 from first post-reset cycle. Reset mid-instruction aborts it, no write.
//  Opcodes: 0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 MOV(rd=rs),7 LDI(rd=next byte),F HALT; 8-E illegal.
//  States:
//   IDLE: instr_ready=1; on valid&ready latch IR -> DECODE; else stay.
//   DECODE: port_a_sel=IR.rd, port_b_sel=IR.rs held from here through WB.
//    ALU ops/MOV -> EXEC; LDI -> IMM; NOP -> IDLE (retired++); HALT -> HALT (retired++);
//    illegal -> illegal_op=1, retired unchanged, -> IDLE.
//   EXEC: alu_op valid, ALU settles -> WB.
//   IMM: instr_ready=1; on handshake latch IMM -> WB; wait indefinitely otherwise.
//   WB: write_en=1 exactly one cycle, write_sel=IR.rd, wr_data=alu_result (ALU/MOV) or IMM (LDI);
//    retired++ ; -> IDLE.
//   HALT: halted=1, instr_ready=0; resume -> IDLE next cycle (halted drops same edge).
//  instr_ready is 0 in DECODE, EXEC, WB, HALT; bytes presented then are not consumed.
//  Latency: ALU/MOV 4 cycles accept-to-write (IDLE,DECODE,EXEC,WB); LDI 3 + imm wait.
//  Max throughput: one ALU instruction per 4 cycles; write occurs on WB->IDLE edge.
//  rd==rs legal: read occurs before write, reads pre-write value.
//  retired wraps 2^CNT_W-1 -> 0 silently. write_en never asserts outside WB.
//  resume outside HALT ignored. reset has priority over every other input.
// STRUCTURE
//  Shared package: opcode constants, alu_op encoding, state enum (IDLE,DECODE,EXEC,IMM,WB,HALT).
//  ALU and register_file stay external; this block is control only.
//  One natural sub-module: instr_decoder (combinational opcode -> alu_op, is_ldi, is_halt, illegal).
// TESTING
//  1 reset then ADD R1,R2 with R1=0x05,R2=0x03 -> write_en one cycle, write_sel=1, wr_data=0x08, retired=1.
//  2 LDI R3 then 0xA5 with 5-cycle gap on imm byte -> ready held in IMM, R3=0xA5 on WB, no early write.
//  3 opcode 0x9 -> illegal_op pulse 1 cycle, no write_en, retired unchanged, back to IDLE.
//  4 HALT -> halted=1, instr_ready=0 with valid held high; resume pulse -> IDLE, next instr accepted.
//  5 reset asserted in EXEC of SUB -> no write_en, all outputs at reset values next cycle.
//  6 255 NOPs + 1 NOP from retired=0 -> retired reaches 0xFF then wraps to 0x00.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file/ALU control sequencer:
// opcode values, ALU operation encoding, FSM states and the decoder output bundle.
package regfile_sequencer_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_IMM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // is_alu covers MOV too: it is an ALU pass-through of port B.
  typedef struct packed {
    alu_op_e alu_op;
    logic    is_alu;
    logic    is_ldi;
    logic    is_halt;
    logic    illegal;
  } decode_t;

endpackage

// File: rtl/regfile_sequencer_instr_decoder.sv
// Combinational opcode decoder: classifies the latched opcode and picks the ALU operation.
module regfile_sequencer_instr_decoder
  import regfile_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    case (opcode)
      OP_NOP: ;
      OP_ADD: begin dec.is_alu = 1'b1; dec.alu_op = ALU_ADD;    end
      OP_SUB: begin dec.is_alu = 1'b1; dec.alu_op = ALU_SUB;    end
      OP_AND: begin dec.is_alu = 1'b1; dec.alu_op = ALU_AND;    end
      OP_OR:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_OR;     end
      OP_XOR: begin dec.is_alu = 1'b1; dec.alu_op = ALU_XOR;    end
      OP_MOV: begin dec.is_alu = 1'b1; dec.alu_op = ALU_PASS_B; end
      OP_LDI:  dec.is_ldi  = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle control FSM for the 4x8 register file and external ALU.
// Handshake: a byte on instr_data is consumed on a rising edge where instr_valid && instr_ready.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int SEL_W_P  = SEL_W,
  parameter int CNT_W_P  = CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [DATA_W_P-1:0] instr_data,
  output logic                instr_ready,
  input  logic                resume,
  input  logic [DATA_W_P-1:0] alu_result,
  output logic                write_en,
  output logic [SEL_W_P-1:0]  write_sel,
  output logic [SEL_W_P-1:0]  port_a_sel,
  output logic [SEL_W_P-1:0]  port_b_sel,
  output logic [2:0]          alu_op,
  output logic [DATA_W_P-1:0] wr_data,
  output logic                halted,
  output logic                illegal_op,
  output logic [CNT_W_P-1:0]  retired,
  output state_e              fsm_state
);

  state_e              state_q, state_d;
  logic [DATA_W_P-1:0] ir_q, imm_q;
  logic [CNT_W_P-1:0]  retired_q;
  logic [2:0]          alu_op_q;
  logic                ir_load, imm_load, alu_load, retire;
  decode_t             dec;

  regfile_sequencer_instr_decoder u_decoder (
    .opcode (ir_q[7:4]),
    .dec    (dec)
  );

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    write_en    = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    ir_load     = 1'b0;
    imm_load    = 1'b0;
    alu_load    = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.illegal) begin
          illegal_op = 1'b1;
          state_d    = S_IDLE;
        end else if (dec.is_ldi) begin
          state_d = S_IMM;
        end else if (dec.is_halt) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else if (dec.is_alu) begin
          alu_load = 1'b1;
          state_d  = S_EXEC;
        end else begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EXEC: state_d = S_WB;
      S_IMM: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          imm_load = 1'b1;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        write_en = 1'b1;
        retire   = 1'b1;
        state_d  = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      imm_q     <= '0;
      retired_q <= '0;
      alu_op_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load)  ir_q      <= instr_data;
      if (imm_load) imm_q     <= instr_data;
      if (alu_load) alu_op_q  <= dec.alu_op;
      if (retire)   retired_q <= retired_q + CNT_W_P'(1);
    end
  end

  // Selects come straight from IR, so they stay stable from DECODE through WB.
  assign port_a_sel = ir_q[3:2];
  assign port_b_sel = ir_q[1:0];
  assign write_sel  = ir_q[3:2];
  assign wr_data    = dec.is_ldi ? imm_q : alu_result;
  assign alu_op     = alu_op_q;
  assign retired    = retired_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboarded bench for regfile_sequencer with a behavioural register file/ALU around it.
module tb_regfile_sequencer;
  import regfile_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, instr_valid, resume;
  logic [7:0] instr_data, alu_result, wr_data, retired;
  logic       instr_ready, write_en, halted, illegal_op;
  logic [1:0] write_sel, port_a_sel, port_b_sel;
  logic [2:0] alu_op;
  state_e     fsm_state;

  int tests_run = 0;
  int fail_cnt  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(instr_ready), .resume(resume), .alu_result(alu_result),
    .write_en(write_en), .write_sel(write_sel), .port_a_sel(port_a_sel),
    .port_b_sel(port_b_sel), .alu_op(alu_op), .wr_data(wr_data), .halted(halted),
    .illegal_op(illegal_op), .retired(retired), .fsm_state(fsm_state)
  );

  // ---------------- external datapath (register file + ALU) ----------------
  logic [7:0] env_regs [4] = '{default: 8'h00};
  always @(posedge clk) if (write_en) env_regs[write_sel] <= wr_data;

  always_comb begin
    case (alu_op)
      3'd0:    alu_result = env_regs[port_a_sel] + env_regs[port_b_sel];
      3'd1:    alu_result = env_regs[port_a_sel] - env_regs[port_b_sel];
      3'd2:    alu_result = env_regs[port_a_sel] & env_regs[port_b_sel];
      3'd3:    alu_result = env_regs[port_a_sel] | env_regs[port_b_sel];
      3'd4:    alu_result = env_regs[port_a_sel] ^ env_regs[port_b_sel];
      3'd5:    alu_result = env_regs[port_b_sel];
      default: alu_result = 8'h00;
    endcase
  end

  // ---------------- reference model ----------------
  int         m_regs [4];
  int         m_retired = 0;
  int         m_illegal = 0;
  int         illegal_seen = 0;
  logic       illegal_prev = 1'b0;
  logic [9:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {22'd0, write_sel, wr_data}, 32'h0);
        if ({write_sel, wr_data} == 10'd0) begin
          fail_cnt++;
          $display("FAIL unexpected_write: write with nothing expected at %0t", $time);
        end
      end else begin
        e = exp_q.pop_front();
        check("write_sel", write_sel, e[9:8]);
        check("wr_data", wr_data, e[7:0]);
      end
    end
    if (illegal_op === 1'b1) illegal_seen++;
    if (illegal_op === 1'b1 && illegal_prev) check("illegal_width", 2, 1);
    illegal_prev = illegal_op;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = b;
    while (!instr_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      check("handshake_timeout", waited, 0);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 instr_valid = 1'b0;
    end
  endtask

  // Updates the model with the architectural effect of one instruction, then drives it.
  task automatic issue(input int op, input int rd, input int rs, input int imm,
                       input int gap, input int imm_gap);
    int a, b, r;
    a = m_regs[rd];
    b = m_regs[rs];
    r = -1;
    case (op)
      0:  m_retired++;
      1:  r = (a + b) % 256;
      2:  r = (a - b + 256) % 256;
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = b;
      7:  r = imm;
      15: m_retired++;
      default: m_illegal++;
    endcase
    if (r >= 0) begin
      exp_q.push_back({rd[1:0], r[7:0]});
      m_regs[rd] = r;
      m_retired++;
    end
    send_byte({op[3:0], rd[1:0], rs[1:0]}, gap);
    if (op == 7) begin
      if (imm_gap > 0) begin
        @(negedge clk);
        repeat (imm_gap) begin
          @(negedge clk);
          check("imm_wait_ready", instr_ready, 1);
          check("imm_wait_no_write", write_en, 0);
        end
      end
      send_byte(imm[7:0], 0);
    end
  endtask

  task automatic drain_check(input string tag);
    repeat (6) @(negedge clk);
    check({tag, "_retired"}, retired, m_retired[7:0]);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_illegal_cnt"}, illegal_seen, m_illegal);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, fsm_state, S_IDLE);
    check({tag, "_ready"}, instr_ready, 1);
    check({tag, "_write_en"}, write_en, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_illegal"}, illegal_op, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_sels"}, {port_a_sel, port_b_sel, write_sel}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    foreach (m_regs[i]) m_regs[i] = 0;
    reset = 1'b1; instr_valid = 1'b0; resume = 1'b0; instr_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    // ADD R1,R2 with R1=5, R2=3
    issue(7, 1, 0, 8'h05, 0, 0);
    issue(7, 2, 0, 8'h03, 0, 0);
    issue(1, 1, 2, 0, 0, 0);
    drain_check("add");
    check("add_env_r1", env_regs[1], 8'h08);

    // LDI R3 with a 5-cycle gap before the immediate
    issue(7, 3, 0, 8'hA5, 0, 5);
    drain_check("ldi");
    check("ldi_env_r3", env_regs[3], 8'hA5);

    // Illegal opcode
    issue(9, 2, 1, 0, 0, 0);
    drain_check("illegal");

    // HALT with a byte held valid, then resume
    issue(15, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = 8'h00;
    repeat (3) begin
      check("halt_halted", halted, 1);
      check("halt_ready", instr_ready, 0);
      @(negedge clk);
    end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_ready", instr_ready, 1);
    m_retired++;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    drain_check("halt");
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_ignored", fsm_state, S_IDLE);

    // Reset in the EXEC cycle of SUB
    send_byte(8'h26, 0);
    @(negedge clk);
    @(negedge clk);
    check("sub_in_exec", fsm_state, S_EXEC);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_retired = 0;
    check_reset_outputs("mid_reset");
    drain_check("mid_reset");

    // Retired counter wrap
    repeat (255) issue(0, 0, 0, 0, 0, 0);
    drain_check("nop255");
    check("wrap_ff", retired, 8'hFF);
    issue(0, 0, 0, 0, 0, 0);
    drain_check("nop256");
    check("wrap_00", retired, 8'h00);

    // Randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 14);
      issue(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255),
            $urandom_range(0, 2), $urandom_range(0, 3));
    end
    drain_check("random");
    for (int i = 0; i < 4; i++) check("final_reg", env_regs[i], m_regs[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
